pipe_trace_buffer: RTL

- Parametrised trigger-based capture buffer for processor debug, sitting beside the pipelined core at the top level.
- Replaces the fixed, live-only debug ports with stored history. Each cycle it can record one sample (e.g. a pipeline latch vector or ALU result) together with a cycle stamp into a circular buffer.
- A trigger stops capture a programmable number of samples later.
- The stored window is then read out oldest-first through a request/valid interface.

---
 rtl/pipe_trace_buffer_if.sv | 30 +++
 rtl/pipe_trace_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer_if.sv
// rtl/pipe_trace_buffer_if.sv - capture/readout signal bundle for the trace buffer
interface pipe_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CYC_W  = 32
) ();
  logic              arm;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              trig_in;
  logic [ADDR_W:0]   post_trig;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic [CYC_W-1:0]  rd_stamp;
  logic              rd_trig;
  logic              rd_valid;
  logic              rd_last;
  logic [1:0]        state;
  logic [ADDR_W:0]   entries;

  modport master (
    output arm, sample_valid, sample_data, trig_in, post_trig, rd_req,
    input  rd_data, rd_stamp, rd_trig, rd_valid, rd_last, state, entries
  );

  modport slave (
    input  arm, sample_valid, sample_data, trig_in, post_trig, rd_req,
    output rd_data, rd_stamp, rd_trig, rd_valid, rd_last, state, entries
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - trigger-based circular capture buffer with oldest-first readout
module pipe_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CYC_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  pipe_trace_buffer_if.slave bus
);

  localparam int              ENT_W    = 1 + CYC_W + DATA_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] POST_MAX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   entries_q, entries_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [CYC_W-1:0]  rd_stamp_q, rd_stamp_d;
  logic              rd_trig_q, rd_trig_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;

  // Entry layout: {trig flag, stamp, data}
  logic [ENT_W-1:0]  buf_q [DEPTH];
  logic [ENT_W-1:0]  rd_entry;
  logic              buf_we;
  logic              buf_wtrig;
  logic              go_done;
  logic [ADDR_W:0]   post_clamp;

  assign rd_entry = buf_q[rptr_q];

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + 1'b1;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    entries_d   = entries_q;
    remaining_d = remaining_q;
    post_cnt_d  = post_cnt_q;
    pend_d      = pend_q;
    rd_data_d   = rd_data_q;
    rd_stamp_d  = rd_stamp_q;
    rd_trig_d   = rd_trig_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    buf_we      = 1'b0;
    buf_wtrig   = 1'b0;
    go_done     = 1'b0;
    post_clamp  = (bus.post_trig > POST_MAX) ? POST_MAX : bus.post_trig;

    if (bus.arm) begin
      state_d   = S_ARMED;
      entries_d = '0;
      wptr_d    = '0;
      pend_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (bus.trig_in) begin
            post_cnt_d = post_clamp;
            if (bus.sample_valid) begin
              buf_we    = 1'b1;
              buf_wtrig = 1'b1;
              if (post_clamp == '0) begin
                go_done = 1'b1;
              end else begin
                state_d = S_POST;
              end
            end else begin
              pend_d  = 1'b1;
              state_d = S_POST;
            end
          end else if (bus.sample_valid) begin
            buf_we = 1'b1;
          end
        end
        S_POST: begin
          if (bus.sample_valid) begin
            buf_we = 1'b1;
            if (pend_q) begin
              // The deferred trigger sample itself is not a post sample.
              buf_wtrig = 1'b1;
              pend_d    = 1'b0;
              go_done   = (post_cnt_q == '0);
            end else begin
              post_cnt_d = post_cnt_q - 1'b1;
              go_done    = (post_cnt_q == (ADDR_W+1)'(1));
            end
          end
        end
        S_DONE: begin
          if (bus.rd_req && (remaining_q != '0)) begin
            rd_valid_d  = 1'b1;
            rd_data_d   = rd_entry[DATA_W-1:0];
            rd_stamp_d  = rd_entry[DATA_W +: CYC_W];
            rd_trig_d   = rd_entry[ENT_W-1];
            rd_last_d   = (remaining_q == (ADDR_W+1)'(1));
            rptr_d      = rptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == (ADDR_W+1)'(1)) begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    if (buf_we) begin
      wptr_d    = wptr_q + 1'b1;
      entries_d = (entries_q == DEPTH_C) ? entries_q : entries_q + 1'b1;
    end

    // Readout window is derived from the pointer/count after this edge's write.
    if (go_done) begin
      state_d     = S_DONE;
      rptr_d      = (entries_d == DEPTH_C) ? wptr_d : '0;
      remaining_d = entries_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      entries_q   <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
      pend_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_stamp_q  <= '0;
      rd_trig_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      entries_q   <= entries_d;
      remaining_q <= remaining_d;
      post_cnt_q  <= post_cnt_d;
      pend_q      <= pend_d;
      rd_data_q   <= rd_data_d;
      rd_stamp_q  <= rd_stamp_d;
      rd_trig_q   <= rd_trig_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && buf_we) begin
      buf_q[wptr_q] <= {buf_wtrig, cyc_q, bus.sample_data};
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_stamp = rd_stamp_q;
  assign bus.rd_trig  = rd_trig_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.state    = state_q;
  assign bus.entries  = entries_q;

endmodule
